// File: rtl/network_sink_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | network_sink_scheduler: serialises a fire vector as count + ascending indices. |
// | Rev 1.0                                                                        |
// +--------------------------------------------------------------------------------+
module network_sink_scheduler #(
   parameter  int NET_NUM_OUT = 8,
   localparam int SNK_WIDTH   = $clog2(NET_NUM_OUT + 1)
) (
   input  logic                   clk,
   input  logic                   arst,
   input  logic                   net_valid,
   output logic                   net_ready,
   input  logic [NET_NUM_OUT-1:0] net_out,
   input  logic                   snk_ready,
   output logic                   snk_valid,
   output logic [SNK_WIDTH-1:0]   snk,
   output logic                   busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_SCAN  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [NET_NUM_OUT-1:0] vec_q, vec_d;
   logic [NET_NUM_OUT-1:0] vec_cleared;
   logic [SNK_WIDTH-1:0]   popcnt;
   logic [SNK_WIDTH-1:0]   low_idx;

   // The count is recomputed from the stored vector, so vec is the only datapath register.
   always_comb begin
      popcnt  = '0;
      low_idx = '0;
      for (int i = 0; i < NET_NUM_OUT; i++) begin
         popcnt = popcnt + SNK_WIDTH'(vec_q[i]);
      end
      for (int i = NET_NUM_OUT - 1; i >= 0; i--) begin
         if (vec_q[i]) low_idx = SNK_WIDTH'(i);
      end
   end

   assign vec_cleared = vec_q & (vec_q - NET_NUM_OUT'(1));

   always_comb begin
      state_d   = state_q;
      vec_d     = vec_q;
      net_ready = 1'b0;
      snk_valid = 1'b0;
      snk       = '0;
      case (state_q)
         ST_IDLE: begin
            net_ready = 1'b1;
            if (net_valid) begin
               vec_d   = net_out;
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            snk_valid = 1'b1;
            snk       = popcnt;
            if (snk_ready) state_d = (vec_q == '0) ? ST_IDLE : ST_SCAN;
         end
         ST_SCAN: begin
            snk_valid = 1'b1;
            snk       = low_idx;
            if (snk_ready) begin
               vec_d   = vec_cleared;
               state_d = (vec_cleared == '0) ? ST_IDLE : ST_SCAN;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_network_sink_scheduler.sv
`default_nettype none
// Directed bench for network_sink_scheduler with NET_NUM_OUT=8.
module tb_network_sink_scheduler;

   localparam int N  = 8;
   localparam int SW = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          arst = 1'b1;
   logic          net_valid = 1'b0;
   logic          net_ready;
   logic [N-1:0]  net_out = '0;
   logic          snk_ready = 1'b1;
   logic          snk_valid;
   logic [SW-1:0] snk;
   logic          busy;

   int n_cmp  = 0;
   int n_fail = 0;

   int   beats[$];
   int   frame_cycles;
   logic busy_ok;

   network_sink_scheduler #(.NET_NUM_OUT(N)) dut (
      .clk       (clk),
      .arst      (arst),
      .net_valid (net_valid),
      .net_ready (net_ready),
      .net_out   (net_out),
      .snk_ready (snk_ready),
      .snk_valid (snk_valid),
      .snk       (snk),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one vector, then records every beat until net_ready returns.
   task automatic run_frame(input logic [N-1:0] v);
      beats.delete();
      busy_ok = 1'b1;
      frame_cycles = 0;
      net_valid = 1'b1;
      net_out   = v;
      tick();
      net_valid = 1'b0;
      net_out   = ~v;
      while (frame_cycles < 20) begin
         if (busy !== 1'b1 || net_ready !== 1'b0) busy_ok = 1'b0;
         if (snk_valid === 1'b1 && snk_ready === 1'b1) beats.push_back(int'(snk));
         tick();
         frame_cycles++;
         if (net_ready === 1'b1) break;
      end
      n_cmp++;
      if (net_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_timeout: net_ready=%b required 1 after %0d cycles", net_ready, frame_cycles);
      end
   endtask

   task automatic check_frame(input string name, input int exp[$], input int exp_cycles);
      n_cmp++;
      if (beats.size() !== exp.size()) begin
         n_fail++;
         $display("FAIL %s_len: got %0d beats, required %0d", name, beats.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < beats.size(); i++) begin
         n_cmp++;
         if (beats[i] !== exp[i]) begin
            n_fail++;
            $display("FAIL %s_beat%0d: got %0d, required %0d", name, i, beats[i], exp[i]);
         end
      end
      n_cmp++;
      if (frame_cycles !== exp_cycles) begin
         n_fail++;
         $display("FAIL %s_cycles: got %0d, required %0d", name, frame_cycles, exp_cycles);
      end
      n_cmp++;
      if (busy_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_busy: busy/net_ready wrong during frame, got flag %b required 1", name, busy_ok);
      end
   endtask

   task automatic test_reset();
      #1;
      n_cmp++;
      if ({net_ready, snk_valid, snk, busy} !== {1'b1, 1'b0, {SW{1'b0}}, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs: ready=%b valid=%b snk=%0d busy=%b, required 1 0 0 0",
                  net_ready, snk_valid, snk, busy);
      end
      tick();
      arst = 1'b0;
      tick();
      n_cmp++;
      if (net_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: ready=%b busy=%b, required 1 0", net_ready, busy);
      end
   endtask

   task automatic test_sparse();
      run_frame(8'b1010_0100);
      check_frame("sparse", '{3, 2, 5, 7}, 4);
   endtask

   task automatic test_empty();
      run_frame(8'h00);
      check_frame("empty", '{0}, 1);
   endtask

   task automatic test_full();
      run_frame(8'hFF);
      check_frame("full", '{8, 0, 1, 2, 3, 4, 5, 6, 7}, 9);
   endtask

   task automatic test_backpressure();
      net_valid = 1'b1;
      net_out   = 8'b0001_0010;
      tick();
      net_valid = 1'b0;
      net_out   = 8'hFF;
      n_cmp++;
      if (snk_valid !== 1'b1 || snk !== SW'(2)) begin
         n_fail++;
         $display("FAIL bp_count: valid=%b snk=%0d, required 1 2", snk_valid, snk);
      end
      tick();
      snk_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (snk_valid !== 1'b1 || snk !== SW'(1) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold%0d: valid=%b snk=%0d busy=%b, required 1 1 1", i, snk_valid, snk, busy);
         end
         tick();
      end
      snk_ready = 1'b1;
      n_cmp++;
      if (snk_valid !== 1'b1 || snk !== SW'(1)) begin
         n_fail++;
         $display("FAIL bp_release: valid=%b snk=%0d, required 1 1", snk_valid, snk);
      end
      tick();
      n_cmp++;
      if (snk_valid !== 1'b1 || snk !== SW'(4)) begin
         n_fail++;
         $display("FAIL bp_last: valid=%b snk=%0d, required 1 4", snk_valid, snk);
      end
      tick();
      n_cmp++;
      if (net_ready !== 1'b1 || snk_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_idle: ready=%b valid=%b, required 1 0", net_ready, snk_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [2*SW-1:0] exp_seq [6];
      exp_seq = '{{1'b1, 1'b1, SW'(1)}, {1'b1, 1'b1, SW'(0)}, {1'b0, 1'b0, SW'(0)},
                  {1'b1, 1'b1, SW'(1)}, {1'b1, 1'b1, SW'(7)}, {1'b0, 1'b0, SW'(0)}};
      net_valid = 1'b1;
      net_out   = 8'h01;
      tick();
      net_out   = 8'h80;
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if ({busy, snk_valid, snk} !== exp_seq[i][SW+1:0]) begin
            n_fail++;
            $display("FAIL b2b_cycle%0d: busy/valid/snk=%b, required %b", i,
                     {busy, snk_valid, snk}, exp_seq[i][SW+1:0]);
         end
         if (i == 3) net_valid = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset_mid_frame();
      net_valid = 1'b1;
      net_out   = 8'hF0;
      tick();
      net_valid = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (snk_valid !== 1'b1 || snk !== SW'(5)) begin
         n_fail++;
         $display("FAIL rst_pre: valid=%b snk=%0d, required 1 5", snk_valid, snk);
      end
      #2 arst = 1'b1;
      #1;
      n_cmp++;
      if (snk_valid !== 1'b0 || net_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_async: valid=%b ready=%b busy=%b, required 0 1 0", snk_valid, net_ready, busy);
      end
      tick();
      arst = 1'b0;
      tick();
      run_frame(8'h02);
      check_frame("post_rst", '{1, 1}, 2);
   endtask

   initial begin
      test_reset();
      test_sparse();
      test_empty();
      test_full();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
